// File: rtl/kbd_axil_regs.sv
// AXI4-Lite keyboard register block: REG0-3 scratch, keycode FIFO with STATUS/KEYDATA/CTRL (optional irq via KBD_AXIL_IRQ_EN).
// Latency: write takes effect on the edge both AW and W are held, with BVALID the next cycle; RVALID rises 1 cycle after the AR handshake.
// Backpressure: one write and one read outstanding; READYs stay low until BREADY/RREADY complete the response; keycodes arriving while the FIFO is full are dropped and flagged.
module kbd_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            key_valid,
   input  logic [7:0]                      key_code
`ifdef KBD_AXIL_IRQ_EN
   ,
   output logic                            irq
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic        aw_held, w_held;
   logic [4:0]  aw_addr_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        awready, wready, bvalid, aw_fire, w_fire, do_write;
   logic [1:0]  bresp_q;

   logic        arready, rvalid, ar_fire;
   logic [31:0] rdata_q, rd_val;
   logic [1:0]  rresp_q;
   logic        rd_err;
   logic [2:0]  rd_sel;

   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [2:0]  wr_sel;

   logic [31:0] regs [4];

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, overflow;
   logic          push, pop, flush, ov_set, ov_clr;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

   // ---------------- write channel ----------------
   always_ff @(posedge ACLK) begin
      if (ARESET) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next   = w_state;
      awready  = 1'b0;
      wready   = 1'b0;
      bvalid   = 1'b0;
      aw_fire  = 1'b0;
      w_fire   = 1'b0;
      do_write = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !aw_held && !ARESET;
            wready  = !w_held && !ARESET;
            aw_fire = S_AXI_AWVALID && awready;
            w_fire  = S_AXI_WVALID && wready;
            if ((aw_held || aw_fire) && (w_held || w_fire)) begin
               do_write = 1'b1;
               w_next   = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (S_AXI_BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign S_AXI_AWREADY = awready;
   assign S_AXI_WREADY  = wready;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp_q;

   // Address and data may each arrive first; whichever is not yet held comes straight from the bus.
   assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
   assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
   assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
   assign wr_sel  = wr_addr[4:2];

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else if (do_write) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bresp_q <= (wr_sel == 3'd7) ? RESP_SLVERR : RESP_OKAY;
      end else begin
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= S_AXI_AWADDR;
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (do_write && !wr_sel[2]) begin
         for (int b = 0; b < 4; b++)
            if (wr_strb[b]) regs[wr_sel[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   assign flush  = do_write && (wr_sel == 3'd6) && wr_data[0];
   assign ov_clr = do_write && (wr_sel == 3'd6) && wr_data[1];

   // ---------------- read channel ----------------
   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      ar_fire = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = !ARESET;
            ar_fire = S_AXI_ARVALID && arready;
            if (ar_fire) r_next = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (S_AXI_RREADY) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign S_AXI_ARREADY = arready;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign rd_sel        = S_AXI_ARADDR[4:2];

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      case (rd_sel)
         3'd0, 3'd1, 3'd2, 3'd3: rd_val = regs[rd_sel[1:0]];
         3'd4: rd_val = {21'b0, overflow, full, empty, 8'(count)};
         3'd5: rd_val = {23'b0, !empty, empty ? 8'h00 : mem[rd_ptr]};
         3'd7: rd_err = 1'b1;
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_fire) begin
         rdata_q <= rd_val;
         rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // ---------------- keycode FIFO ----------------
   assign empty  = (count == '0);
   assign full   = (count == CW'(FIFO_DEPTH));
   assign pop    = ar_fire && (rd_sel == 3'd5) && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the key.
   assign push   = key_valid && !flush && (!full || pop);
   assign ov_set = key_valid && !flush && full && !pop;

   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr] <= key_code;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET)      overflow <= 1'b0;
      else if (ov_set) overflow <= 1'b1;
      else if (ov_clr) overflow <= 1'b0;
   end

`ifdef KBD_AXIL_IRQ_EN
   always_ff @(posedge ACLK) begin
      if (ARESET) irq <= 1'b0;
      else        irq <= regs[0][0] && (!empty || overflow);
   end
`endif

endmodule

// File: tb/tb_kbd_axil_regs.sv
// Directed bench for kbd_axil_regs: register map, byte strobes, keycode FIFO, write-channel ordering, error responses.
module tb_kbd_axil_regs;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [4:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [4:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        key_valid;
   logic [7:0]  key_code;
`ifdef KBD_AXIL_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ACLK = ~ACLK;

   kbd_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .FIFO_DEPTH(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .key_valid(key_valid), .key_code(key_code)
`ifdef KBD_AXIL_IRQ_EN
      , .irq(irq)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      logic aw_hs, w_hs, b_hs, done;
      done          = 1'b0;
      resp          = 2'bxx;
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_BREADY  = 1'b1;
      for (int i = 0; i < 32 && !done; i++) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         b_hs  = S_AXI_BVALID && S_AXI_BREADY;
         if (b_hs) resp = S_AXI_BRESP;
         tick();
         if (aw_hs) S_AXI_AWVALID = 1'b0;
         if (w_hs)  S_AXI_WVALID  = 1'b0;
         if (b_hs)  done = 1'b1;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b0;
      check_eq("write_done", {31'b0, done}, 32'd1);
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic ar_hs, r_hs, done;
      done          = 1'b0;
      data          = 'x;
      resp          = 2'bxx;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      S_AXI_RREADY  = 1'b1;
      for (int i = 0; i < 32 && !done; i++) begin
         ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
         r_hs  = S_AXI_RVALID && S_AXI_RREADY;
         if (r_hs) begin
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
         end
         tick();
         if (ar_hs) S_AXI_ARVALID = 1'b0;
         if (r_hs)  done = 1'b1;
      end
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      check_eq("read_done", {31'b0, done}, 32'd1);
   endtask

   task automatic push_key(input logic [7:0] code);
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
   endtask

   logic [31:0] rd;
   logic [1:0]  rsp;
   logic [31:0] reg_exp [4];

   initial begin
      reg_exp[0] = 32'h1; reg_exp[1] = 32'h2; reg_exp[2] = 32'h3; reg_exp[3] = 32'h4;
      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      key_valid = 1'b0; key_code = '0;

      // reset state
      repeat (3) tick();
      check_eq("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
      check_eq("rst_wready",  {31'b0, S_AXI_WREADY},  32'd0);
      check_eq("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
      check_eq("rst_bvalid",  {31'b0, S_AXI_BVALID},  32'd0);
      check_eq("rst_rvalid",  {31'b0, S_AXI_RVALID},  32'd0);
      check_eq("rst_rdata",   S_AXI_RDATA, 32'd0);
      check_eq("rst_resps",   {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
`ifdef KBD_AXIL_IRQ_EN
      check_eq("rst_irq", {31'b0, irq}, 32'd0);
`endif
      ARESET = 1'b0;
      tick();
      check_eq("post_rst_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
      check_eq("post_rst_arready", {31'b0, S_AXI_ARREADY}, 32'd1);
      axi_read(5'h10, rd, rsp);
      check_eq("status_reset", rd, 32'h100);

      // REG0-REG3 write/readback
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(4 * i), reg_exp[i], 4'hF, rsp);
         check_eq("reg_bresp", {30'b0, rsp}, 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(5'(4 * i), rd, rsp);
         check_eq("reg_rd", rd, reg_exp[i]);
         check_eq("reg_rresp", {30'b0, rsp}, 32'd0);
      end

      // byte strobes on a cleared REG1
      axi_write(5'h04, 32'h0, 4'hF, rsp);
      axi_write(5'h04, 32'hAABBCCDD, 4'b0101, rsp);
      axi_read(5'h04, rd, rsp);
      check_eq("wstrb_0101", rd, 32'h00BB00DD);

      // FIFO basic push/pop
      push_key(8'h1C);
      push_key(8'h32);
      axi_read(5'h10, rd, rsp);
      check_eq("status_two", rd, 32'h002);
      axi_read(5'h14, rd, rsp);
      check_eq("keydata_1", rd, 32'h11C);
      axi_read(5'h14, rd, rsp);
      check_eq("keydata_2", rd, 32'h132);
      axi_read(5'h14, rd, rsp);
      check_eq("keydata_empty", rd, 32'h000);
      axi_read(5'h10, rd, rsp);
      check_eq("status_empty", rd, 32'h100);

      // overflow then flush/clear
      for (int i = 0; i < 17; i++) push_key(8'(8'h40 + i));
      axi_read(5'h10, rd, rsp);
      check_eq("status_overflow", rd, 32'h610);
      axi_read(5'h14, rd, rsp);
      check_eq("keydata_head_after_full", rd, 32'h140);
      axi_read(5'h10, rd, rsp);
      check_eq("status_after_pop", rd, 32'h40F);
      axi_write(5'h18, 32'h3, 4'hF, rsp);
      check_eq("ctrl_bresp", {30'b0, rsp}, 32'd0);
      axi_read(5'h10, rd, rsp);
      check_eq("status_flushed", rd, 32'h100);
      axi_read(5'h18, rd, rsp);
      check_eq("ctrl_reads_zero", rd, 32'h0);

      // W leads AW by 3 cycles; B held off for 4 cycles
      S_AXI_WDATA  = 32'h5A5A0001;
      S_AXI_WSTRB  = 4'hF;
      S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b0;
      tick();
      check_eq("w_first_wready_low", {31'b0, S_AXI_WREADY}, 32'd0);
      check_eq("w_first_awready_hi", {31'b0, S_AXI_AWREADY}, 32'd1);
      check_eq("w_first_no_b", {31'b0, S_AXI_BVALID}, 32'd0);
      tick();
      tick();
      S_AXI_AWADDR  = 5'h08;
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_eq("bvalid_held", {31'b0, S_AXI_BVALID}, 32'd1);
         check_eq("bresp_held", {30'b0, S_AXI_BRESP}, 32'd0);
         tick();
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("no_second_b", {31'b0, S_AXI_BVALID}, 32'd0);
         tick();
      end
      axi_read(5'h08, rd, rsp);
      check_eq("w_first_reg2", rd, 32'h5A5A0001);

      // unmapped and read-only addresses
      axi_read(5'h1C, rd, rsp);
      check_eq("unmapped_rresp", {30'b0, rsp}, 32'h2);
      check_eq("unmapped_rdata", rd, 32'h0);
      axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, rsp);
      check_eq("unmapped_bresp", {30'b0, rsp}, 32'h2);
      axi_write(5'h10, 32'hFFFFFFFF, 4'hF, rsp);
      check_eq("ro_write_bresp", {30'b0, rsp}, 32'h0);
      axi_read(5'h10, rd, rsp);
      check_eq("ro_status_intact", rd, 32'h100);

`ifdef KBD_AXIL_IRQ_EN
      axi_write(5'h00, 32'h1, 4'hF, rsp);
      tick();
      check_eq("irq_idle", {31'b0, irq}, 32'd0);
      push_key(8'h5A);
      tick();
      check_eq("irq_set", {31'b0, irq}, 32'd1);
      axi_read(5'h14, rd, rsp);
      check_eq("irq_pop_data", rd, 32'h15A);
      tick();
      check_eq("irq_clear", {31'b0, irq}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
